// File: rtl/issue_scoreboard.sv
// Registered decode/issue stage for a MIPS pipeline. It decodes the source
// registers, destination and result latency of each instruction. A countdown
// scoreboard holds back any instruction that reads a register whose
// multi-cycle result (load or mul/div) is not yet available.
module issue_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 2,
    localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT,
    localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_ins,
    input  logic [31:0]   in_pc,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_ins,
    output logic [31:0]   out_pc,
    output logic [4:0]    out_dst,
    output logic          out_wr,
    output logic [CW-1:0] out_lat,
    output logic          stall
);

    localparam logic [CW-1:0] LAT_LOAD = CW'(LOAD_LAT);
    localparam logic [CW-1:0] LAT_MUL  = CW'(MUL_LAT);

    // Instruction fields
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] hint;
    logic       mul_hint;

    assign opcode   = in_ins[31:26];
    assign rs       = in_ins[25:21];
    assign rt       = in_ins[20:16];
    assign rd       = in_ins[15:11];
    assign hint     = in_ins[10:6];
    assign funct    = in_ins[5:0];
    assign mul_hint = hint == 5'd2 || hint == 5'd3;

    // Raw decode results
    logic          use_rs;
    logic          use_rt;
    logic          dec_wr_raw;
    logic [4:0]    dec_dst_raw;
    logic [CW-1:0] dec_lat;

    // Final destination: a write to $0 is no write at all
    logic          dec_wr;
    logic [4:0]    dec_dst;

    // Handshake and hazard signals
    logic adv;
    logic hazard;
    logic accept;

    // Scoreboard counters; cnt_view[0] is a constant zero so that $0 never stalls
    logic [CW-1:0] cnt_reg  [1:31];
    logic [CW-1:0] cnt_view [0:31];

    // Decode source usage, destination and latency class from the instruction word
    always_comb begin
        use_rs      = 1'b0;
        use_rt      = 1'b0;
        dec_wr_raw  = 1'b0;
        dec_dst_raw = 5'd0;
        dec_lat     = '0;
        case (opcode)
            6'h00: begin
                use_rs      = 1'b1;
                use_rt      = 1'b1;
                dec_wr_raw  = 1'b1;
                dec_dst_raw = rd;
                case (funct)
                    6'h00, 6'h02, 6'h03: use_rs = 1'b0;          // shifts by immediate
                    6'h08: begin                                  // JR
                        use_rt     = 1'b0;
                        dec_wr_raw = 1'b0;
                    end
                    6'h09: use_rt = 1'b0;                         // JALR
                    6'h0C, 6'h0D: begin                           // SYSCALL / BREAK
                        use_rs     = 1'b0;
                        use_rt     = 1'b0;
                        dec_wr_raw = 1'b0;
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin             // mul/div family
                        if (mul_hint) begin
                            dec_lat = LAT_MUL;
                        end
                    end
                    default: ;
                endcase
            end
            6'h01: begin                                          // REGIMM
                use_rs = 1'b1;
                if (rt == 5'b10001) begin
                    dec_wr_raw  = 1'b1;
                    dec_dst_raw = 5'd31;
                end
            end
            6'h02: ;                                              // J
            6'h03: begin                                          // JAL
                dec_wr_raw  = 1'b1;
                dec_dst_raw = 5'd31;
            end
            6'h04, 6'h05: begin                                   // BEQ / BNE
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'h06, 6'h07: use_rs = 1'b1;                          // BLEZ / BGTZ
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin                     // ALU immediate / AUI
                use_rs      = 1'b1;
                dec_wr_raw  = 1'b1;
                dec_dst_raw = rt;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin              // loads
                use_rs      = 1'b1;
                dec_wr_raw  = 1'b1;
                dec_dst_raw = rt;
                dec_lat     = LAT_LOAD;
            end
            6'h28, 6'h29, 6'h2B: begin                            // stores
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'h10: begin                                          // COP0
                if (rs == 5'b00000) begin
                    dec_wr_raw  = 1'b1;
                    dec_dst_raw = rt;
                end else if (rs == 5'b00100) begin
                    use_rt = 1'b1;
                end
            end
            6'h1F: begin                                          // SPECIAL3
                use_rs      = 1'b1;
                use_rt      = 1'b1;
                dec_wr_raw  = 1'b1;
                dec_dst_raw = rt;
            end
            default: ;
        endcase
    end

    assign dec_wr  = dec_wr_raw && (dec_dst_raw != 5'd0);
    assign dec_dst = dec_wr ? dec_dst_raw : 5'd0;

    assign cnt_view[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cnt
            assign cnt_view[gi] = cnt_reg[gi];

            // Reload on a writing accept, otherwise count down while the pipe advances
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (accept && dec_wr && dec_dst == 5'(gi)) begin
                    cnt_reg[gi] <= dec_lat;
                end else if (adv && cnt_reg[gi] != '0) begin
                    cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
                end
            end
        end
    endgenerate

    assign adv      = !out_valid || out_ready;
    assign hazard   = (use_rs && rs != 5'd0 && cnt_view[rs] != '0) ||
                      (use_rt && rt != 5'd0 && cnt_view[rt] != '0);
    assign in_ready = adv && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && hazard;

    // Output register: load on accept, drop valid when consumed or flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ins   <= 32'd0;
            out_pc    <= 32'd0;
            out_dst   <= 5'd0;
            out_wr    <= 1'b0;
            out_lat   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ins   <= in_ins;
            out_pc    <= in_pc;
            out_dst   <= dec_dst;
            out_wr    <= dec_wr;
            out_lat   <= dec_lat;
        end else if (out_ready || flush) begin
            out_valid <= 1'b0;
        end
    end

endmodule
